serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial WIDTH-bit subtractor computing `a - b` one bit per clock, LSB first, through a single one-bit full-subtract cell and a registered borrow. It sits upstream of the one-bit subtract cell: it feeds that cell its operand bits and borrow-in, and collects its difference and borrow-out. It uses a valid/ready handshake on both sides so it can sit between a producer and a consumer in an arithmetic datapath. It trades latency for area against a parallel ripple subtractor.

## Interface
- `WIDTH`, default 8, operand/result width in bits; legal range 1..32.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: operands `a`, `b` are valid.
- `in_ready` output 1: block is idle and can accept operands.
- `a` input WIDTH: minuend, unsigned.
- `b` input WIDTH: subtrahend, unsigned.
- `out_valid` output 1: result is valid and held.
- `out_ready` input 1: consumer takes the result.
- `diff` output WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow` output 1: final borrow-out; 1 iff a < b.
- `zero` output 1: 1 iff `diff == 0`.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid && in_ready`: latch `a` and `b` into shift registers, clear the borrow register, clear the bit counter, go to SHIFT.
- SHIFT, each cycle:
  - Feed the cell `x=a_sh[0]`, `y=b_sh[0]`, `bin=borrow_q`.
  - Cell equations: `d = x^y^bin`; `bout = (~x&y) | (~x&bin) | (y&bin)`.
  - Shift `d` into the MSB of the result register, which shifts right.
  - Shift `a_sh` and `b_sh` right by one.
  - `borrow_q <= bout`; counter increments.
  - When the counter reaches WIDTH-1 on this edge, go to DONE and register `zero` from the final result.
- DONE:
  - `out_valid=1`; `diff`, `borrow`, `zero` are held stable.
  - On `out_valid && out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- Counter width is `$clog2(WIDTH+1)`. WIDTH=1 does one SHIFT cycle.
- `diff` and `borrow` may change during SHIFT. Consumers sample them only while `out_valid=1`.

## Timing
- Reset values, asserted asynchronously while `rst_n=0`:
  - state IDLE, `in_ready=1`, `out_valid=0`;
  - `diff=0`, `borrow=0`, `zero=0`;
  - shift registers and counter cleared.
- Latency: operands accepted at edge k → `out_valid` high after edge k+WIDTH.
- Earliest output handshake is edge k+WIDTH+1. `in_ready` is high after that edge. Next accept is edge k+WIDTH+2.
- Minimum initiation interval: WIDTH+2 cycles.
- No same-cycle accept while in DONE; input and output handshakes never coincide.
- Backpressure: with `out_ready=0`, DONE holds indefinitely and outputs do not change.
- Reset mid-SHIFT or mid-DONE: the operation is discarded and the block is in IDLE with reset values on the first cycle after `rst_n` rises. No partial result is ever flagged valid.
- `in_ready` and `out_valid` are decoded from registered state only; no combinational path from inputs to outputs.

## Structure
- Shared arithmetic package:
  - FSM state enum (IDLE/SHIFT/DONE), 2 bits;
  - `SUB_MAX_WIDTH = 32`.
- One sub-module: `sub_bit_cell` (inputs `x`, `y`, `bin`; outputs `d`, `bout`; purely combinational, equations as above). Instantiate it once.
- Top level holds the FSM, counter, shift registers, borrow flop and result register.

## Test plan
- WIDTH=8, a=20, b=7 → `out_valid` 8 cycles after accept; diff=13, borrow=0, zero=0.
- a=7, b=20 → diff=8'hF3, borrow=1, zero=0. Also a=8'h00, b=8'h01 → diff=8'hFF, borrow=1.
- a=b=8'h5A → diff=0, borrow=0, zero=1. Also a=8'hFF, b=0 → diff=8'hFF, borrow=0.
- Hold `out_ready=0` for 5 cycles in DONE → outputs stable, `in_ready=0`. Pulse `in_valid` with new operands meanwhile → ignored; first result is unchanged.
- Drop `rst_n` at SHIFT bit 3 → `out_valid=0`, `in_ready=1`, `diff=0` immediately. After release, a=100, b=1 → diff=99.
- Back-to-back ops with `in_valid`/`out_ready` tied high → accepts every 10 cycles; WIDTH=1 case: 0-1 → diff=1, borrow=1.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_subtractor_pkg;

    localparam int unsigned SUB_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_e;

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full-subtract cell: d = x - y - bin, with borrow-out.
module sub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single subtract cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    if (WIDTH < 1 || WIDTH > SUB_MAX_WIDTH) begin : g_width_check
        $error("serial_subtractor: WIDTH out of range");
    end

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_sh, a_d;
    logic [WIDTH-1:0] b_sh, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             cell_d, cell_bout;

    sub_bit_cell u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_sh;
        b_d      = b_sh;
        res_d    = res_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_d      = a_sh >> 1;
                b_d      = b_sh >> 1;
                res_d    = (res_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    zero_d  = (res_d == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // Handshake flags track the next state so they are valid the cycle the state is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh        <= '0;
            b_sh        <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            a_sh        <= a_d;
            b_sh        <= b_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            borrow_q    <= borrow_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = res_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       borrow;
    logic       zero;

    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       out_valid1;
    logic       out_ready1 = 1'b0;
    logic [0:0] diff1;
    logic       borrow1;
    logic       zero1;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .zero(zero)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .borrow(borrow1), .zero(zero1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Accept one operand pair, time the latency, check the result, then hand it off.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input logic ez);
        int n;
        in_valid = 1'b1;
        a = av;
        b = bv;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            if (!out_valid) n++;
        end
        if (!out_valid) n = 99;
        check({tag, "_lat"}, 32'(n), 32'd8);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow), 32'(eb));
        check({tag, "_zero"}, 32'(zero), 32'(ez));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ovdrop"}, 32'(out_valid), 32'd0);
        check({tag, "_irdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int acc[$];
        int n;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("s20m7", 8'd20, 8'd7, 8'd13, 1'b0, 1'b0);
        run_op("s7m20", 8'd7, 8'd20, 8'hF3, 1'b1, 1'b0);
        run_op("s0m1", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op("eq5a", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1);
        run_op("ffm0", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);

        // Backpressure: hold DONE, pulse in_valid with other operands.
        in_valid = 1'b1;
        a = 8'h33;
        b = 8'h11;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            a = 8'h01;
            b = 8'h02;
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_diff", 32'(diff), 32'h22);
            check("bp_borrow", 32'(borrow), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", 32'(in_ready), 32'd1);

        // Reset in the middle of a shift.
        in_valid = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_diff", 32'(diff), 32'd0);
        check("mrst_borrow", 32'(borrow), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(out_valid), 32'd0);
        run_op("s100m1", 8'd100, 8'd1, 8'd99, 1'b0, 1'b0);

        // Back-to-back with both handshakes tied high: 50 - 60 = 0xF6.
        in_valid = 1'b1;
        out_ready = 1'b1;
        a = 8'd50;
        b = 8'd60;
        for (int i = 0; i < 32; i++) begin
            if (in_ready) acc.push_back(i);
            if (out_valid) begin
                check("b2b_diff", 32'(diff), 32'hF6);
                check("b2b_borrow", 32'(borrow), 32'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_accepts", 32'(acc.size()), 32'd4);
        for (int i = 1; i < acc.size(); i++) begin
            check("b2b_interval", 32'(acc[i] - acc[i-1]), 32'd10);
        end
        n = 0;
        while (!in_ready && n < 40) begin
            out_ready = out_valid;
            tick();
            n++;
        end
        out_ready = 1'b0;

        // WIDTH=1: one shift cycle per operation.
        in_valid1 = 1'b1;
        a1 = 1'b0;
        b1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        check("w1_busy", 32'(out_valid1), 32'd0);
        tick();
        check("w1_valid", 32'(out_valid1), 32'd1);
        check("w1_diff", 32'(diff1), 32'd1);
        check("w1_borrow", 32'(borrow1), 32'd1);
        check("w1_zero", 32'(zero1), 32'd0);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check("w1_idle", 32'(in_ready1), 32'd1);
        in_valid1 = 1'b1;
        a1 = 1'b1;
        b1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        tick();
        check("w1_eq_valid", 32'(out_valid1), 32'd1);
        check("w1_eq_diff", 32'(diff1), 32'd0);
        check("w1_eq_borrow", 32'(borrow1), 32'd0);
        check("w1_eq_zero", 32'(zero1), 32'd1);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
